// File: rtl/key_input_ctrl.sv
// Key-input sequencer: scanner clock/enable, key handshake into a small FIFO,
// and decode of buffered keys into cursor moves, placement requests and passes.
module key_input_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int BOARD_SIZE = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  output logic       o_scan_clk,
  output logic       o_kb_en,
  input  logic       i_key_valid,
  input  logic [3:0] i_pressed_index,
  output logic       o_key_received,
  output logic [4:0] o_cursor_x,
  output logic [4:0] o_cursor_y,
  output logic       o_player,
  output logic       o_place_req,
  output logic [4:0] o_place_x,
  output logic [4:0] o_place_y,
  input  logic       i_place_ack,
  input  logic       i_place_ok,
  output logic       o_pass_pulse
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [4:0] C_MAX = 5'(BOARD_SIZE - 1);
  localparam logic [4:0] C_MID = 5'(BOARD_SIZE / 2);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_PLACE_WAIT} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_scan_clk;
  logic             r_kb_en;
  logic [3:0]       r_fifo_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_key_received;
  logic [3:0]       r_code;
  logic [4:0]       r_cur_x;
  logic [4:0]       r_cur_y;
  logic             r_player;
  logic             r_place_req;
  logic [4:0]       r_place_x;
  logic [4:0]       r_place_y;
  logic             r_pass_pulse;

  logic w_empty;
  logic w_full;
  logic w_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_enable && i_key_valid && !r_key_received && !w_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt  <= '0;
      r_scan_clk <= 1'b0;
      r_kb_en    <= 1'b0;
    end else begin
      r_kb_en <= i_enable;
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt  <= '0;
        r_scan_clk <= ~r_scan_clk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr[AW-1:0]] <= i_pressed_index;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_key_received <= 1'b0;
      r_code         <= 4'h0;
      r_cur_x        <= C_MID;
      r_cur_y        <= C_MID;
      r_player       <= 1'b0;
      r_place_req    <= 1'b0;
      r_place_x      <= 5'd0;
      r_place_y      <= 5'd0;
      r_pass_pulse   <= 1'b0;
    end else if (!i_enable) begin
      // Game paused: abandon any pending request and queued keys, keep the position.
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_key_received <= 1'b0;
      r_place_req    <= 1'b0;
      r_pass_pulse   <= 1'b0;
    end else begin
      r_key_received <= w_push;
      r_pass_pulse   <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_code   <= r_fifo_mem[r_rd_ptr[AW-1:0]];
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_IDLE;
          case (r_code)
            4'h1: if (r_cur_y != 5'd0)  r_cur_y <= r_cur_y - 5'd1;
            4'h9: if (r_cur_y != C_MAX) r_cur_y <= r_cur_y + 5'd1;
            4'h4: if (r_cur_x != 5'd0)  r_cur_x <= r_cur_x - 5'd1;
            4'h6: if (r_cur_x != C_MAX) r_cur_x <= r_cur_x + 5'd1;
            4'hC: begin
              r_cur_x <= C_MID;
              r_cur_y <= C_MID;
            end
            4'hF: begin
              r_pass_pulse <= 1'b1;
              r_player     <= ~r_player;
            end
            4'h5: begin
              r_place_x   <= r_cur_x;
              r_place_y   <= r_cur_y;
              r_place_req <= 1'b1;
              r_state     <= S_PLACE_WAIT;
            end
            default: ;
          endcase
        end
        S_PLACE_WAIT: begin
          if (i_place_ack) begin
            r_place_req <= 1'b0;
            if (i_place_ok) r_player <= ~r_player;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_scan_clk     = r_scan_clk;
  assign o_kb_en        = r_kb_en;
  assign o_key_received = r_key_received;
  assign o_cursor_x     = r_cur_x;
  assign o_cursor_y     = r_cur_y;
  assign o_player       = r_player;
  assign o_place_req    = r_place_req;
  assign o_place_x      = r_place_x;
  assign o_place_y      = r_place_y;
  assign o_pass_pulse   = r_pass_pulse;

endmodule
